// File: rtl/inst_fetch_aligner_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_aligner_if
// Purpose  : Bus bundle around the instruction fetch aligner. It carries the
//            instruction-memory read port, the redirect request and the
//            decode-facing valid/ready output stage.
// Modports : master - the fetch aligner (drives imem_addr and out_*)
//            slave  - the environment (memory, branch unit, decode)
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_aligner_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic              out_compressed;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_compressed
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_compressed
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_aligner
// Purpose  : RV32IC fetch front end. Reads one 32-bit word per cycle from a
//            combinational-read instruction memory, splits/reassembles 16-bit
//            halfwords into whole RV32I or RVC instructions and presents them
//            to decode through a registered valid/ready stage. RVC
//            instructions are passed through unexpanded as {16'h0, half}.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - inst_fetch_aligner_if.master (imem read port, redirect,
//                   decode output stage)
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_aligner #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_fetch_aligner_if.master bus
);

  logic [31:0]       r_pc;
  logic [ADDR_W-1:0] r_fetch_word;
  logic              r_spill_valid;
  logic [15:0]       r_spill_half;
  logic              r_out_valid;
  logic [31:0]       r_out_inst;
  logic [31:0]       r_out_pc;
  logic              r_out_compressed;

  logic        w_advance;
  logic [15:0] w_lo;
  logic [15:0] w_hi;
  logic        w_lo_rvc;
  logic        w_hi_rvc;
  logic        w_spill_rvc;
  logic        w_unused;

  // Output stage may load a new instruction when empty or being drained.
  assign w_advance   = !r_out_valid || bus.out_ready;
  assign w_lo        = bus.imem_data[15:0];
  assign w_hi        = bus.imem_data[31:16];
  assign w_lo_rvc    = (w_lo[1:0] != 2'b11);
  assign w_hi_rvc    = (w_hi[1:0] != 2'b11);
  assign w_spill_rvc = (r_spill_half[1:0] != 2'b11);

  // PC bit 0 is forced to zero on redirect, so the incoming bit is dropped.
  assign w_unused = bus.redirect_pc[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_fetch_word     <= RESET_PC[ADDR_W+1:2];
      r_spill_valid    <= 1'b0;
      r_spill_half     <= 16'h0;
      r_out_valid      <= 1'b0;
      r_out_inst       <= 32'h0;
      r_out_pc         <= 32'h0;
      r_out_compressed <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Any pending output was either taken this edge or is now stale.
      r_pc          <= {bus.redirect_pc[31:1], 1'b0};
      r_fetch_word  <= bus.redirect_pc[ADDR_W+1:2];
      r_spill_valid <= 1'b0;
      r_out_valid   <= 1'b0;
    end else if (w_advance) begin
      if (r_spill_valid) begin
        // Held upper half is the start of the next instruction.
        r_out_valid <= 1'b1;
        r_out_pc    <= r_pc;
        if (w_spill_rvc) begin
          // Word at imem_addr is not consumed; it is read again next cycle.
          r_out_inst       <= {16'h0, r_spill_half};
          r_out_compressed <= 1'b1;
          r_pc             <= r_pc + 32'd2;
          r_spill_valid    <= 1'b0;
        end else begin
          r_out_inst       <= {w_lo, r_spill_half};
          r_out_compressed <= 1'b0;
          r_pc             <= r_pc + 32'd4;
          r_spill_half     <= w_hi;
          r_fetch_word     <= r_fetch_word + 1'b1;
        end
      end else if (!r_pc[1]) begin
        // Word-aligned start.
        r_out_valid  <= 1'b1;
        r_out_pc     <= r_pc;
        r_fetch_word <= r_fetch_word + 1'b1;
        if (w_lo_rvc) begin
          r_out_inst       <= {16'h0, w_lo};
          r_out_compressed <= 1'b1;
          r_pc             <= r_pc + 32'd2;
          r_spill_valid    <= 1'b1;
          r_spill_half     <= w_hi;
        end else begin
          r_out_inst       <= bus.imem_data;
          r_out_compressed <= 1'b0;
          r_pc             <= r_pc + 32'd4;
        end
      end else begin
        // Halfword-aligned start with no spill: only reachable after a
        // redirect to an odd-halfword target.
        r_fetch_word <= r_fetch_word + 1'b1;
        if (w_hi_rvc) begin
          r_out_valid      <= 1'b1;
          r_out_pc         <= r_pc;
          r_out_inst       <= {16'h0, w_hi};
          r_out_compressed <= 1'b1;
          r_pc             <= r_pc + 32'd2;
        end else begin
          // First half of a straddling 32-bit instruction: one bubble while
          // the second half is fetched.
          r_out_valid   <= 1'b0;
          r_spill_valid <= 1'b1;
          r_spill_half  <= w_hi;
        end
      end
    end
  end

  assign bus.imem_addr      = r_fetch_word;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_inst       = r_out_inst;
  assign bus.out_pc         = r_out_pc;
  assign bus.out_compressed = r_out_compressed;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_aligner
// Purpose  : Self-checking bench for inst_fetch_aligner. Directed cycle-exact
//            scenarios followed by a randomized run compared against a
//            halfword-stream reference model of the instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_aligner;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst;
  logic [31:0] mem [DEPTH];

  int checks;
  int failures;

  inst_fetch_aligner_if #(.ADDR_W(ADDR_W)) bus ();

  inst_fetch_aligner #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the memory is a flat stream of halfwords addressed by
  // byte PC (word index wraps with the memory size).
  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[ADDR_W+1:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic model_inst(input logic [31:0] pc, output logic [31:0] inst,
                            output logic comp, output logic [31:0] len);
    logic [15:0] h0;
    h0 = half_at(pc);
    if (h0[1:0] != 2'b11) begin
      inst = {16'h0, h0};
      comp = 1'b1;
      len  = 32'd2;
    end else begin
      inst = {half_at(pc + 32'd2), h0};
      comp = 1'b0;
      len  = 32'd4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic comp);
    chk({tag, "_valid"}, {31'h0, bus.out_valid}, 32'd1);
    chk({tag, "_inst"},  bus.out_inst, inst);
    chk({tag, "_pc"},    bus.out_pc, pc);
    chk({tag, "_c"},     {31'h0, bus.out_compressed}, {31'h0, comp});
  endtask

  task automatic chk_addr(input string tag, input int exp);
    chk(tag, {{(32-ADDR_W){1'b0}}, bus.imem_addr}, exp[31:0]);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect_cycle(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  logic [31:0] mpc, einst, elen, rp, p_inst, p_pc;
  logic        ecomp, rdy, redir, hold, p_c;
  logic [ADDR_W-1:0] p_addr;
  int accepted;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;

    // ---- Plain RV32I with backpressure on the first instruction ----
    clear_mem();
    mem[0] = 32'h00002083;
    mem[1] = 32'h00402103;
    do_reset();
    chk("rst_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_inst", bus.out_inst, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_c", {31'h0, bus.out_compressed}, 32'd0);
    chk_addr("rst_addr", 0);
    bus.out_ready = 1'b1;
    tick();
    expect_out("plain0", 32'h00002083, 32'h0, 1'b0);
    chk_addr("plain0_addr", 1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("bp_hold", 32'h00002083, 32'h0, 1'b0);
      chk_addr("bp_addr", 1);
    end
    bus.out_ready = 1'b1;
    tick();
    expect_out("plain1", 32'h00402103, 32'h4, 1'b0);
    chk_addr("plain1_addr", 2);

    // ---- Packed RVC pair ----
    clear_mem();
    mem[0] = 32'h00850085;
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    expect_out("pack0", 32'h00000085, 32'h0, 1'b1);
    chk_addr("pack0_addr", 1);
    tick();
    expect_out("pack1", 32'h00000085, 32'h2, 1'b1);
    chk_addr("pack1_addr", 1);

    // ---- Straddling 32-bit instruction ----
    clear_mem();
    mem[0] = 32'h20830085;
    mem[1] = 32'h01050000;
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    expect_out("str0", 32'h00000085, 32'h0, 1'b1);
    tick();
    expect_out("str1", 32'h00002083, 32'h2, 1'b0);
    tick();
    expect_out("str2", 32'h00000105, 32'h6, 1'b1);

    // ---- Redirect to an odd halfword ----
    clear_mem();
    mem[1] = 32'h20830000;
    mem[2] = 32'h00010000;
    do_reset();
    bus.out_ready = 1'b1;
    redirect_cycle(32'h6);
    chk("odd_redir_valid", {31'h0, bus.out_valid}, 32'd0);
    tick();
    chk("odd_bubble_valid", {31'h0, bus.out_valid}, 32'd0);
    tick();
    expect_out("odd0", 32'h00002083, 32'h6, 1'b0);
    tick();
    expect_out("odd1", 32'h00000001, 32'hA, 1'b1);

    // ---- Word address wrap ----
    clear_mem();
    mem[63] = 32'h00302183;
    mem[0]  = 32'h00402203;
    do_reset();
    bus.out_ready = 1'b1;
    redirect_cycle(32'hFC);
    chk("wrap_redir_valid", {31'h0, bus.out_valid}, 32'd0);
    chk_addr("wrap_addr63", 63);
    tick();
    expect_out("wrap0", 32'h00302183, 32'hFC, 1'b0);
    chk_addr("wrap_addr0", 0);
    tick();
    expect_out("wrap1", 32'h00402203, 32'h100, 1'b0);
    chk_addr("wrap_addr1", 1);

    // ---- Redirect coincident with an accepted output ----
    clear_mem();
    mem[0] = 32'h00002083;
    mem[1] = 32'h00402103;
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    expect_out("coin_pre", 32'h00002083, 32'h0, 1'b0);
    redirect_cycle(32'h4);
    chk("coin_redir_valid", {31'h0, bus.out_valid}, 32'd0);
    tick();
    expect_out("coin_post", 32'h00402103, 32'h4, 1'b0);

    // ---- Randomized run against the halfword-stream model ----
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] h0, h1;
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      if ($urandom_range(1, 0) == 1) h0[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) h1[1:0] = 2'b11;
      mem[i] = {h1, h0};
    end
    do_reset();
    mpc      = 32'h0;
    accepted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy   = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(39, 0) == 0);
      rp    = $urandom;
      bus.out_ready      = rdy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rp;
      if (bus.out_valid && rdy) begin
        model_inst(mpc, einst, ecomp, elen);
        chk("rnd_inst", bus.out_inst, einst);
        chk("rnd_pc", bus.out_pc, mpc);
        chk("rnd_c", {31'h0, bus.out_compressed}, {31'h0, ecomp});
        mpc = mpc + elen;
        accepted++;
      end
      hold   = bus.out_valid && !rdy && !redir;
      p_inst = bus.out_inst;
      p_pc   = bus.out_pc;
      p_c    = bus.out_compressed;
      p_addr = bus.imem_addr;
      tick();
      if (redir) mpc = {rp[31:1], 1'b0};
      if (hold) begin
        chk("rnd_hold_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("rnd_hold_inst", bus.out_inst, p_inst);
        chk("rnd_hold_pc", bus.out_pc, p_pc);
        chk("rnd_hold_c", {31'h0, bus.out_compressed}, {31'h0, p_c});
        chk("rnd_hold_addr", {{(32-ADDR_W){1'b0}}, bus.imem_addr},
            {{(32-ADDR_W){1'b0}}, p_addr});
      end
    end
    bus.redirect_valid = 1'b0;
    // Progress bound: with ~70% ready the stream must keep flowing.
    chk("rnd_progress", {31'h0, (accepted > 1000)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/inst_fetch_aligner.md
# inst_fetch_aligner

Instruction fetch front end for the RV32IC core. It is the reading side of the instruction memory interface. Each cycle it drives a word address into the combinational-read instruction memory and consumes the returned 32-bit word. It splits and reassembles 16-bit halfwords into whole RV32I or RVC instructions, then presents them to decode through a registered valid/ready output stage. Compressed instructions are passed through unexpanded; expansion happens in the decoder.

## Interface
- ADDR_W, 6: word-address width of instruction memory (2^ADDR_W words)
- RESET_PC, 32'h0: PC fetched after reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  word address to instruction memory; equals fetch_word register
- imem_data  in  32  instruction word at imem_addr, valid same cycle (combinational read)
- redirect_valid  in  1  branch/jump redirect request
- redirect_pc  in  32  redirect target; bit 0 ignored
- out_valid  out  1  out_inst/out_pc/out_compressed valid
- out_ready  in  1  decode accepts this cycle
- out_inst  out  32  instruction; RVC as {16'h0, half}
- out_pc  out  32  PC of out_inst
- out_compressed  out  1  out_inst is a 16-bit RVC instruction

## Operation
- State registers:
  - pc[31:0]: next instruction to assemble, always even.
  - fetch_word[ADDR_W-1:0]: next word to read.
  - spill_valid, spill_half[15:0]: upper half of the last word read; meaningful only when pc[1]=1.
- A halfword is RVC when h[1:0] != 2'b11.
- advance = !out_valid || out_ready. When advance=0 with no redirect, all state and outputs hold.
- When advance=1 with no redirect, let W = imem_data:
  - A, spill_valid=0, pc[1]=0:
    - W[1:0]!=11: emit {16'h0, W[15:0]}, compressed=1, pc+=2, spill=W[31:16] (valid).
    - otherwise: emit W, pc+=4.
    - Both cases: fetch_word+=1.
  - B, spill_valid=1:
    - spill RVC: emit it, pc+=2, spill_valid=0, fetch_word unchanged (no word consumed).
    - otherwise: emit {W[15:0], spill_half}, pc+=4, spill=W[31:16] (valid), fetch_word+=1.
  - C, spill_valid=0, pc[1]=1 (only after a redirect):
    - W[31:16] RVC: emit it, pc+=2, fetch_word+=1.
    - otherwise: spill=W[31:16] (valid), fetch_word+=1, emit nothing. out_valid<=0 for one bubble; case B follows.
- Emit means out_valid<=1, with out_inst, out_pc (the old pc) and out_compressed loaded.
- Redirect has priority over everything:
  - pc<={redirect_pc[31:1],1'b0}, fetch_word<=redirect_pc[ADDR_W+1:2].
  - spill_valid<=0, out_valid<=0.
  - An out_valid&&out_ready transfer in the same cycle still counts as accepted by decode.
- Arithmetic and wrap-around:
  - fetch_word wraps modulo 2^ADDR_W.
  - pc is a full 32-bit counter and is not truncated.
- Reset:
  - pc=RESET_PC, fetch_word=RESET_PC[ADDR_W+1:2], spill_valid=0, spill_half=0.
  - out_valid=0, out_inst=0, out_pc=0, out_compressed=0.
  - Reset mid-operation discards the spill and the pending output.

## Timing
- imem_addr is a pure register output.
- Output latency is one cycle from the edge on which state selects a word to out_valid.
- After reset release, the first instruction is valid one cycle after the first edge with rst=0.
- Throughput is one instruction per cycle when out_ready=1, except the single case-C bubble.
- Redirect: out_valid is low in the cycle after the redirect edge. The target instruction appears the next cycle, or two cycles later if it is a 32-bit instruction at pc[1]=1.
- While out_valid=1 and out_ready=0, out_inst/out_pc/out_compressed are stable and imem_addr is unchanged.

## Test plan
- Plain RV32I: mem[0]=32'h00002083, mem[1]=32'h00402103, ready=1.
  - Required: (00002083, pc 0, c=0) then (00402103, pc 4, c=0).
  - Required: imem_addr 0,1,2.
- Packed RVC: mem[0]=32'h00850085.
  - Required: (00000085, pc 0, c=1) then (00000085, pc 2, c=1).
  - Required: imem_addr stays 1 for the second instruction.
- Straddle: mem[0]=32'h20830085, mem[1]=32'h01050000.
  - Required: (00000085, pc 0), (00002083, pc 2, c=0), (00000105, pc 6, c=1), with no bubble.
- Backpressure: in the plain test, hold out_ready=0 for 3 cycles on the first instruction.
  - Required: out_inst=00002083 and out_pc=0 stable, imem_addr=1 stable.
  - Required: the second instruction appears the cycle after ready rises.
- Odd redirect: mem[1]=32'h20830000, mem[2]=32'h00010000, redirect_pc=6.
  - Required: one cycle out_valid=0, then one bubble, then (00002083, pc 6, c=0), then (00000001, pc 10, c=1).
- Wrap plus simultaneous events:
  - ADDR_W=6, redirect_pc=32'hFC with 32-bit words. Required: imem_addr 63 then 0, out_pc FC then 100.
  - Redirect coincident with an accepted output. Required: that output counts as taken and nothing stale follows.
